// File: rtl/cpu_defs.sv
// Shared CP0 definitions: operation codes, register indices, bit positions
// and reset constants used by the CP0 register bank and its timer.
package cpu_defs;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MTC0 = 3'd1,
        OP_MFC0 = 3'd2,
        OP_EXC  = 3'd3,
        OP_ERET = 3'd4
    } cp0_op_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } acc_state_t;

    // CP0 register indices (all at select 0)
    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_WIRED    = 5'd6;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    // Status bit positions
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_BEV = 22;

    // Cause bit positions
    localparam int CAUSE_BD = 31;
    localparam int CAUSE_TI = 30;

    // Software-writable bits
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Reset constants
    localparam logic [31:0] STATUS_RST = 32'h0040_0000;
    localparam logic [31:0] PRID_RST   = 32'h0001_8000;
    localparam logic [31:0] CONFIG_RST = 32'h8000_0083;

    // Merge the writable bits of a new value into an old register value
    function automatic logic [31:0] apply_mask(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// Count/Compare timer: prescaled Count, Compare register and sticky TI flag.
module cp0_count_timer
    import cpu_defs::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic [2:0] PRE_MAX = 3'(COUNT_DIV - 1);

    logic [2:0]  pre_q, pre_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        tick_s;
    logic [31:0] count_inc_s;

    assign tick_s      = (pre_q == PRE_MAX);
    assign count_inc_s = count_q + 32'd1;

    // Next-state for prescaler, Count, Compare and TI; writes beat ticks, Compare clear beats match
    always_comb begin
        pre_d     = pre_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (count_we) begin
            count_d = wdata;
            pre_d   = 3'd0;
        end else if (tick_s) begin
            count_d = count_inc_s;
            pre_d   = 3'd0;
        end else begin
            pre_d   = pre_q + 3'd1;
        end

        if (compare_we) begin
            compare_d = wdata;
        end else begin
            compare_d = compare_q;
        end

        if (compare_we) begin
            ti_d = 1'b0;
        end else if (!count_we && tick_s && (count_inc_s == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q     <= 3'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_timer_core.sv
// CP0 register bank with Random, interrupt pending logic and a
// valid/ready access handshake whose response latency is ACC_LAT cycles.
module cp0_timer_core
    import cpu_defs::*;
#(
    parameter int INDEX_WIDTH = 5,
    parameter int N_EXT_INT   = 6,
    parameter int COUNT_DIV   = 2,
    parameter int ACC_LAT     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_EXT_INT-1:0] ext_int,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  cp0_op_t              req_op,
    input  logic [4:0]           req_addr,
    input  logic [2:0]           req_sel,
    input  logic [31:0]          req_wdata,
    input  logic [4:0]           exc_code,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_epc,
    input  logic                 exc_badva_valid,
    input  logic [31:0]          exc_badva,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic [31:0]          epc,
    output logic [31:0]          status,
    output logic [31:0]          cause,
    output logic                 int_req,
    output logic                 timer_int
);

    localparam logic [INDEX_WIDTH-1:0] RAND_TOP = {INDEX_WIDTH{1'b1}};
    localparam logic [1:0]             LAT_INIT = 2'(ACC_LAT - 1);

    // Handshake FSM
    acc_state_t state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;

    // Register bank
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] random_q, random_d;
    logic [INDEX_WIDTH-1:0] wired_q, wired_d;
    logic [31:0]            badva_q, badva_d;
    logic [31:0]            status_q, status_d;
    logic [31:0]            epc_q, epc_d;
    logic [4:0]             exc_code_q, exc_code_d;
    logic                   bd_q, bd_d;
    logic [1:0]             sw_ip_q, sw_ip_d;
    logic [5:0]             ip_hw_q, ip_hw_d;

    // Decode and timer signals
    logic        accept_s, mtc0_s, exc_s, eret_s;
    logic        wr_index_s, wr_wired_s, wr_count_s, wr_compare_s;
    logic        wr_status_s, wr_cause_s, wr_epc_s;
    logic [31:0] count_s, compare_s;
    logic        ti_s;
    logic [31:0] cause_s;
    logic [31:0] rd_mux_s;
    logic        int_s;

    assign accept_s     = req_valid & ready_q;
    assign mtc0_s       = accept_s && (req_op == OP_MTC0) && (req_sel == 3'd0);
    assign exc_s        = accept_s && (req_op == OP_EXC);
    assign eret_s       = accept_s && (req_op == OP_ERET);
    assign wr_index_s   = mtc0_s && (req_addr == CP0_INDEX);
    assign wr_wired_s   = mtc0_s && (req_addr == CP0_WIRED);
    assign wr_count_s   = mtc0_s && (req_addr == CP0_COUNT);
    assign wr_compare_s = mtc0_s && (req_addr == CP0_COMPARE);
    assign wr_status_s  = mtc0_s && (req_addr == CP0_STATUS);
    assign wr_cause_s   = mtc0_s && (req_addr == CP0_CAUSE);
    assign wr_epc_s     = mtc0_s && (req_addr == CP0_EPC);

    cp0_count_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count_s),
        .compare_we (wr_compare_s),
        .wdata      (req_wdata),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // IP7 carries the timer in addition to the highest hardware line
    assign cause_s = {bd_q, ti_s, 14'd0, ip_hw_q[5] | ti_s, ip_hw_q[4:0],
                      sw_ip_q, 1'b0, exc_code_q, 2'b00};

    assign int_s = status_q[ST_IE] & ~status_q[ST_EXL] &
                   (|(cause_s[15:8] & status_q[15:8]));

    // Read mux over the pre-write register state
    always_comb begin
        rd_mux_s = 32'd0;
        if (req_sel == 3'd0) begin
            case (req_addr)
                CP0_INDEX:    rd_mux_s = {{(32-INDEX_WIDTH){1'b0}}, index_q};
                CP0_RANDOM:   rd_mux_s = {{(32-INDEX_WIDTH){1'b0}}, random_q};
                CP0_WIRED:    rd_mux_s = {{(32-INDEX_WIDTH){1'b0}}, wired_q};
                CP0_BADVADDR: rd_mux_s = badva_q;
                CP0_COUNT:    rd_mux_s = count_s;
                CP0_COMPARE:  rd_mux_s = compare_s;
                CP0_STATUS:   rd_mux_s = status_q;
                CP0_CAUSE:    rd_mux_s = cause_s;
                CP0_EPC:      rd_mux_s = epc_q;
                CP0_PRID:     rd_mux_s = PRID_RST;
                CP0_CONFIG:   rd_mux_s = CONFIG_RST;
                default:      rd_mux_s = 32'd0;
            endcase
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    // Register bank next-state: MTC0 writes, exception entry, ERET and Random
    always_comb begin
        index_d    = index_q;
        wired_d    = wired_q;
        random_d   = random_q;
        badva_d    = badva_q;
        status_d   = status_q;
        epc_d      = epc_q;
        exc_code_d = exc_code_q;
        bd_d       = bd_q;
        sw_ip_d    = sw_ip_q;
        ip_hw_d    = 6'(ext_int);

        if (wr_index_s) begin
            index_d = req_wdata[INDEX_WIDTH-1:0];
        end else begin
            index_d = index_q;
        end

        if (wr_wired_s) begin
            wired_d  = req_wdata[INDEX_WIDTH-1:0];
            random_d = RAND_TOP;
        end else if (random_q == wired_q) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
        end

        if (wr_status_s) begin
            status_d = apply_mask(status_q, req_wdata, STATUS_WMASK);
        end else if (exc_s) begin
            status_d[ST_EXL] = 1'b1;
        end else if (eret_s) begin
            status_d[ST_EXL] = 1'b0;
        end else begin
            status_d = status_q;
        end

        if (wr_epc_s) begin
            epc_d = req_wdata;
        end else if (exc_s && !status_q[ST_EXL]) begin
            epc_d = exc_epc;
        end else begin
            epc_d = epc_q;
        end

        // A nested exception keeps the original EPC and BD
        if (exc_s) begin
            exc_code_d = exc_code;
            bd_d       = status_q[ST_EXL] ? bd_q : exc_bd;
        end else begin
            exc_code_d = exc_code_q;
            bd_d       = bd_q;
        end

        if (exc_s && exc_badva_valid) begin
            badva_d = exc_badva;
        end else begin
            badva_d = badva_q;
        end

        if (wr_cause_s) begin
            sw_ip_d = req_wdata[9:8];
        end else begin
            sw_ip_d = sw_ip_q;
        end
    end

    // Handshake FSM next-state and registered response signals
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_BUSY;
                    lat_d   = LAT_INIT;
                    rdata_d = (req_op == OP_MFC0) ? rd_mux_s : 32'd0;
                end else begin
                    state_d = S_IDLE;
                    lat_d   = 2'd0;
                end
            end
            S_BUSY: begin
                if (lat_q == 2'd0) begin
                    state_d = S_IDLE;
                    lat_d   = 2'd0;
                end else begin
                    state_d = S_BUSY;
                    lat_d   = lat_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                lat_d   = 2'd0;
            end
        endcase

        ready_d      = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_BUSY) && (lat_d == 2'd0);
    end

    // FSM and register bank state, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            lat_q        <= 2'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            index_q      <= {INDEX_WIDTH{1'b0}};
            random_q     <= RAND_TOP;
            wired_q      <= {INDEX_WIDTH{1'b0}};
            badva_q      <= 32'd0;
            status_q     <= STATUS_RST;
            epc_q        <= 32'd0;
            exc_code_q   <= 5'd0;
            bd_q         <= 1'b0;
            sw_ip_q      <= 2'd0;
            ip_hw_q      <= 6'd0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            index_q      <= index_d;
            random_q     <= random_d;
            wired_q      <= wired_d;
            badva_q      <= badva_d;
            status_q     <= status_d;
            epc_q        <= epc_d;
            exc_code_q   <= exc_code_d;
            bd_q         <= bd_d;
            sw_ip_q      <= sw_ip_d;
            ip_hw_q      <= ip_hw_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign epc        = epc_q;
    assign status     = status_q;
    assign cause      = cause_s;
    assign int_req    = int_s;
    assign timer_int  = ti_s;

endmodule
